// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32I pipeline.
// Accepts one load or store from the EX/MEM register, issues it on the
// word-addressed data-memory port, and stalls upstream until the response.
// Load results are aligned and extended here, so writeback sees final data.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; faults are flagged combinationally
// ACCESS | strobe held from the captured request until dmem_resp
// DONE   | one cycle, stall released, load result valid (loads only)
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        access_fault_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_is_load;
  logic        r_dmem_read;
  logic        r_dmem_write;
  logic [31:0] r_dmem_address;
  logic [3:0]  r_dmem_byte_enable;
  logic [31:0] r_dmem_wdata;
  logic [31:0] r_load_data;
  logic        r_load_valid;

  logic        w_request;
  logic        w_funct3_ok;
  logic        w_misaligned;
  logic        w_conflict;
  logic        w_illegal;
  logic        w_idle;
  logic        w_accept;
  logic        w_fault;

  // Lane mask: funct3[1:0] encodes width (00 byte, 01 half, 10 word).
  function automatic logic [3:0] f_byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the enabled lanes see the right bytes.
  function automatic logic [31:0] f_store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] f_load_format(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rd >> {off, 3'b000};
    case (f3)
      3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  result = {24'h000000, shifted[7:0]};
      3'b101:  result = {16'h0000, shifted[15:0]};
      default: result = rd;
    endcase
    return result;
  endfunction

  // Request decode and legality; only meaningful while idle.
  always_comb begin
    w_request = valid_in & (mem_read_in | mem_write_in);
    case (funct3_in)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_funct3_ok = 1'b1;
      default:                                w_funct3_ok = 1'b0;
    endcase
    w_misaligned = ((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                   ((funct3_in[1:0] == 2'b10) & (addr_in[1:0] != 2'b00));
    w_conflict   = mem_read_in & mem_write_in;
    w_illegal    = ~w_funct3_ok | w_misaligned | w_conflict;
    // Reset overrides any request seen in the same cycle.
    w_idle       = (r_state == ST_IDLE) & ~rst;
    w_accept     = w_idle & w_request & ~w_illegal;
    w_fault      = w_idle & w_request & w_illegal;
  end

  // Control FSM; strobes, memory-side fields and load result are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_funct3           <= 3'b000;
      r_offset           <= 2'b00;
      r_is_load          <= 1'b0;
      r_dmem_read        <= 1'b0;
      r_dmem_write       <= 1'b0;
      r_dmem_address     <= 32'h0;
      r_dmem_byte_enable <= 4'h0;
      r_dmem_wdata       <= 32'h0;
      r_load_data        <= 32'h0;
      r_load_valid       <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state            <= ST_ACCESS;
            r_funct3           <= funct3_in;
            r_offset           <= addr_in[1:0];
            r_is_load          <= mem_read_in;
            r_dmem_read        <= mem_read_in;
            r_dmem_write       <= mem_write_in;
            r_dmem_address     <= {addr_in[31:2], 2'b00};
            r_dmem_byte_enable <= f_byte_enable(funct3_in, addr_in[1:0]);
            r_dmem_wdata       <= f_store_lanes(funct3_in, wdata_in);
          end
        end
        ST_ACCESS: begin
          if (dmem_resp) begin
            r_state      <= ST_DONE;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (r_is_load) begin
              r_load_data  <= f_load_format(r_funct3, r_offset, dmem_rdata);
              r_load_valid <= 1'b1;
            end
          end
        end
        // Inputs still show the finished instruction here; never re-accept.
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dmem_read  <= 1'b0;
          r_dmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out        = w_accept | (r_state == ST_ACCESS);
  assign access_fault_out = w_fault;
  assign dmem_read        = r_dmem_read;
  assign dmem_write       = r_dmem_write;
  assign dmem_address     = r_dmem_address;
  assign dmem_byte_enable = r_dmem_byte_enable;
  assign dmem_wdata       = r_dmem_wdata;
  assign load_data_out    = r_load_data;
  assign load_valid_out   = r_load_valid;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32I pipeline. It consumes the `mem_read`/`mem_write` requests produced by instruction decode, together with the ALU-computed address, `rs2` store data and `funct3`, and services each request on the word-addressed data-memory port. It generates byte enables and store-data lane replication, sign/zero-extends load data, and stalls the pipeline until the memory responds.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `valid_in` in 1 — EX/MEM register holds a valid instruction.
- `mem_read_in` in 1 — decoded load request.
- `mem_write_in` in 1 — decoded store request.
- `funct3_in` in 3 — access width/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr_in` in 32 — byte address (ALU result).
- `wdata_in` in 32 — store data (`rs2`).
- `stall_out` out 1 — hold all upstream pipeline registers.
- `load_data_out` out 32 — extended load result for writeback.
- `load_valid_out` out 1 — one-cycle pulse; `load_data_out` valid.
- `access_fault_out` out 1 — request rejected (misaligned, illegal `funct3`, or read and write both set).
- `dmem_read` out 1, `dmem_write` out 1 — memory strobes.
- `dmem_address` out 32 — word-aligned address: `{addr[31:2],2'b00}`.
- `dmem_byte_enable` out 4 — lane mask.
- `dmem_wdata` out 32 — lane-replicated store data.
- `dmem_rdata` in 32 — read data.
- `dmem_resp` in 1 — access complete; valid in any cycle a strobe is high.

## Operation
The control FSM has three states: IDLE, ACCESS and DONE.

IDLE:
- A request is `valid_in & (mem_read_in | mem_write_in)`.
- Legal request:
  - Capture `funct3`, `addr`, `wdata` and the direction into internal registers.
  - Assert `stall_out` combinationally in this cycle.
  - Next state is ACCESS.
- Illegal request:
  - `access_fault_out = 1` combinationally, in the same cycle.
  - No strobe and no stall; remain in IDLE.
- Illegal means any of:
  - `funct3` is not one of the listed encodings;
  - halfword access with `addr[0]=1`;
  - word access with `addr[1:0]≠0`;
  - `mem_read_in` and `mem_write_in` both set.

ACCESS:
- `dmem_read` or `dmem_write` is driven from the captured registers and held stable until `dmem_resp`.
- `stall_out` = 1.
- On `dmem_resp`:
  - Register the formatted load data.
  - Next state is DONE.

DONE:
- `stall_out` = 0, and both strobes are 0.
- For loads, `load_valid_out` = 1.
- The pipeline advances at the end of this cycle.
- Inputs in this cycle still describe the completed instruction and are ignored. This guarantees no re-issue.
- Next state is IDLE.

Byte enables, with `o = addr[1:0]`:
- Byte access: `4'b0001 << o`.
- Halfword access: `4'b0011 << o`.
- Word access: `4'b1111`.
- Loads use the same mask.

Store data:
- SB: `{4{wdata[7:0]}}`.
- SH: `{2{wdata[15:0]}}`.
- SW: `wdata` unchanged.

Load formatting:
- Select byte `rdata[8*o +: 8]` or halfword `rdata[8*o +: 16]`.
- LB and LH sign-extend from the top bit; LBU and LHU zero-extend.
- LW passes `rdata` through.

`load_data_out` holds its last value until the next load completes.

## Timing
- Reset values: FSM IDLE. All outputs 0: `stall_out`, `load_valid_out`, `access_fault_out`, `dmem_read`, `dmem_write`, `dmem_byte_enable`, `dmem_address`, `dmem_wdata` and `load_data_out`.
- Request accepted in cycle 0 (IDLE). Strobe high from cycle 1.
- If `dmem_resp` arrives in cycle k (k≥1), DONE is cycle k+1 and the load result is valid in cycle k+1.
- Minimum stall is 2 cycles (resp in cycle 1). Total occupancy is k+2 cycles.
- `dmem_resp` in IDLE or DONE is ignored.
- Reset in any state: IDLE next cycle, and strobes are 0 in that cycle. An in-flight response is discarded, with no `load_valid_out`.
- `rst` has priority over every other input.
- Back-to-back requests: the next instruction is seen in IDLE the cycle after DONE. There are no bubbles beyond the single DONE cycle.

## Test plan
- LW 0x100, `dmem_resp` 3 cycles after the strobe rises, `rdata` 0xDEADBEEF → `dmem_address` 0x100, `byte_enable` 1111, `dmem_read` held 3 cycles, `load_data_out` 0xDEADBEEF with a 1-cycle `load_valid_out` in DONE, `stall_out` low in DONE.
- LB 0x103 with `rdata` 0x80FFFF7F → `byte_enable` 1000, result 0xFFFFFF80. LBU at the same address → 0x00000080. LH 0x102 → 0xFFFF80FF. LHU 0x102 → 0x000080FF.
- SH 0x202 with `wdata` 0x1234ABCD → `dmem_address` 0x200, `byte_enable` 1100, `dmem_wdata` 0xABCDABCD, `dmem_write` only, `load_valid_out` stays 0.
- LW 0x101, SH 0x203, `funct3`=011, and read+write both set → each gives `access_fault_out`=1 in that cycle, no strobe, `stall_out`=0, FSM stays IDLE.
- `rst` asserted in the 2nd ACCESS cycle of a load → strobe 0 the next cycle; a `dmem_resp` pulse after reset produces no `load_valid_out`; a following LW completes normally.
- SW then LW with `dmem_resp` in the first ACCESS cycle each → each completes in 3 cycles (IDLE, ACCESS, DONE), exactly one strobe cycle each, and no duplicate access during DONE.
